dac_spi_serializer: RTL

//  Output end of the adc_dac_frontend DAC path: takes each signed DAC_VALUE sample and shifts it to an external
//  SPI DAC (mode 0, MSB first). Sits between adc_dac_frontend and the FPGA pins, in the same CLK/CE domain.

---
 rtl/dac_spi_serializer_pkg.sv | 25 ++
 rtl/dac_spi_serializer_if.sv | 28 ++
 rtl/dac_spi_serializer_bit_timer.sv | 43 ++++
 rtl/dac_spi_serializer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dac_spi_serializer_pkg.sv
// Shared types and helpers for the DAC SPI serializer.
// Holds the FSM state encoding, the DAC command code and the sample-to-wire conversion.
// No logic of its own.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_HOLD  = 3'd2,
    ST_GAP   = 3'd3,
    ST_LDAC  = 3'd4
  } dac_spi_state_t;

  // "Write input register and update output" command of the DAC.
  localparam logic [3:0] DAC_SPI_CMD_WRITE_UPDATE = 4'b0011;

  // Two's complement -> offset binary: flip the sign bit, keep the low 'width' bits.
  function automatic logic [31:0] to_offset_binary(input logic [31:0] sample,
                                                   input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (sample ^ (32'd1 << (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Sample input, SPI pins and status of the DAC serializer bundled as one interface.
// master: sample producer / pin observer.  slave: the serializer itself.
// DAC_SPI_SERIALIZER_LDAC_EN adds the DAC_LDAC_N pin.
interface dac_spi_if #(
  parameter int DAC_DATA_WIDTH = 12,
  parameter int DROP_CNT_BITS  = 16
);
  logic signed [DAC_DATA_WIDTH-1:0] DAC_VALUE;
  logic                             DAC_VALUE_WE;
  logic                             DAC_CS_N;
  logic                             DAC_SCLK;
  logic                             DAC_SDI;
  logic                             BUSY;
  logic [DROP_CNT_BITS-1:0]         DROP_COUNT;
`ifdef DAC_SPI_SERIALIZER_LDAC_EN
  logic                             DAC_LDAC_N;

  modport master (output DAC_VALUE, DAC_VALUE_WE,
                  input  DAC_CS_N, DAC_SCLK, DAC_SDI, BUSY, DROP_COUNT, DAC_LDAC_N);
  modport slave  (input  DAC_VALUE, DAC_VALUE_WE,
                  output DAC_CS_N, DAC_SCLK, DAC_SDI, BUSY, DROP_COUNT, DAC_LDAC_N);
`else
  modport master (output DAC_VALUE, DAC_VALUE_WE,
                  input  DAC_CS_N, DAC_SCLK, DAC_SDI, BUSY, DROP_COUNT);
  modport slave  (input  DAC_VALUE, DAC_VALUE_WE,
                  output DAC_CS_N, DAC_SCLK, DAC_SDI, BUSY, DROP_COUNT);
`endif
endinterface

// File: rtl/dac_spi_serializer_bit_timer.sv
// Half-period timer for the SPI clock: strobes at the end of every SCLK_HALF CE-cycles.
// Ports: CLK/RESET, ce (enable), en (count), clr (restart at low half) -> half_done, sclk_rise, sclk_fall.
// Strobes are combinational from state and already qualified by ce; no backpressure.
module dac_spi_bit_timer #(
  parameter int SCLK_HALF = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ce,
  input  logic en,
  input  logic clr,
  output logic half_done,
  output logic sclk_rise,
  output logic sclk_fall
);
  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [CW-1:0] cnt_q;
  logic          high_q;   // 0 = low half of the bit, 1 = high half

  assign half_done = ce & en & (cnt_q == CW'(SCLK_HALF - 1));
  assign sclk_rise = half_done & ~high_q;
  assign sclk_fall = half_done & high_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        cnt_q  <= '0;
        high_q <= 1'b0;
      end else if (en) begin
        if (half_done) begin
          cnt_q  <= '0;
          high_q <= ~high_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dac_spi_serializer.sv
// SPI mode-0 serializer for the DAC path: one frame {CMD, offset-binary sample, pad} per sample, MSB first.
// Latency: CS_N falls one CE-cycle after the strobe; default frame period 68 CE-cycles (70 with LDAC).
// No backpressure: one pending slot, newest sample overwrites it and DROP_COUNT counts the loss.
// Ports: CLK, RESET (async, active high), CE, bus (dac_spi_if.slave: sample in, SPI pins, BUSY, DROP_COUNT).
// Option macro DAC_SPI_SERIALIZER_LDAC_EN: adds DAC_LDAC_N pulse after each frame's CS-high gap.
module dac_spi_serializer
  import dac_spi_pkg::*;
#(
  parameter int                  DAC_DATA_WIDTH = 12,
  parameter int                  FRAME_BITS     = 16,
  parameter int                  CMD_BITS       = 4,
  parameter logic [CMD_BITS-1:0] CMD_VALUE      = CMD_BITS'(DAC_SPI_CMD_WRITE_UPDATE),
  parameter int                  SCLK_HALF      = 2,
  parameter int                  CS_HIGH_CYCLES = 2,
  parameter int                  DROP_CNT_BITS  = 16
) (
  input logic      CLK,
  input logic      RESET,
  input logic      CE,
  dac_spi_if.slave bus
);
  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] HOLD  = ST_HOLD;
  localparam logic [2:0] GAP   = ST_GAP;
  localparam logic [2:0] LDAC  = ST_LDAC;

  localparam int PAD = FRAME_BITS - CMD_BITS - DAC_DATA_WIDTH;
  localparam int BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GCW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

  logic [2:0]               state_q, state_d;
  logic [FRAME_BITS-1:0]    shreg_q, pend_word_q, new_word, launch_word;
  logic                     pend_vld_q;
  logic                     cs_n_q, sclk_q, sdi_q;
  logic [DROP_CNT_BITS-1:0] drop_q;
  logic [BCW-1:0]           bit_cnt_q;
  logic [GCW-1:0]           gap_cnt_q;
  logic [DAC_DATA_WIDTH-1:0] ob_data;
  logic we, last_bit, gap_done, frame_exit, launch, launch_pend;
  logic tmr_en, tmr_clr, half_done, sclk_rise, sclk_fall;
`ifdef DAC_SPI_SERIALIZER_LDAC_EN
  logic ldac_n_q;
`endif

  assign we       = CE & bus.DAC_VALUE_WE;
  assign ob_data  = DAC_DATA_WIDTH'(to_offset_binary(32'(bus.DAC_VALUE), DAC_DATA_WIDTH));
  assign new_word = (FRAME_BITS'(CMD_VALUE) << (FRAME_BITS - CMD_BITS)) | (FRAME_BITS'(ob_data) << PAD);
  assign launch_word = launch_pend ? pend_word_q : new_word;

  assign last_bit = (bit_cnt_q == BCW'(FRAME_BITS - 1));
  assign gap_done = CE & (state_q == GAP) & (gap_cnt_q == GCW'(CS_HIGH_CYCLES - 1));

  // Timer restarts on every state change so each timed state begins with a full low half.
  assign tmr_en  = (state_q == SHIFT) | (state_q == HOLD) | (state_q == LDAC);
  assign tmr_clr = (state_d != state_q);

  dac_spi_bit_timer #(.SCLK_HALF(SCLK_HALF)) u_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .ce        (CE),
    .en        (tmr_en),
    .clr       (tmr_clr),
    .half_done (half_done),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_pend = 1'b0;
    frame_exit  = 1'b0;
    case (state_q)
      IDLE:  if (we) begin
               state_d = SHIFT;
               launch  = 1'b1;
             end
      SHIFT: if (sclk_fall && last_bit) state_d = HOLD;
      HOLD:  if (half_done) state_d = GAP;
`ifdef DAC_SPI_SERIALIZER_LDAC_EN
      GAP:   if (gap_done) state_d = LDAC;
      LDAC:  frame_exit = half_done;
`else
      GAP:   frame_exit = gap_done;
`endif
      default: state_d = IDLE;
    endcase
    // End of frame: the pending word goes first; a fresh strobe with an empty slot launches directly.
    if (frame_exit) begin
      if (pend_vld_q) begin
        state_d     = SHIFT;
        launch      = 1'b1;
        launch_pend = 1'b1;
      end else if (we) begin
        state_d = SHIFT;
        launch  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      shreg_q     <= '0;
      pend_word_q <= '0;
      pend_vld_q  <= 1'b0;
      drop_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
`ifdef DAC_SPI_SERIALIZER_LDAC_EN
      ldac_n_q    <= 1'b1;
`endif
    end else if (CE) begin
      state_q   <= state_d;
      cs_n_q    <= !((state_d == SHIFT) || (state_d == HOLD));
      gap_cnt_q <= ((state_q == GAP) && (state_d == GAP)) ? gap_cnt_q + 1'b1 : '0;
`ifdef DAC_SPI_SERIALIZER_LDAC_EN
      ldac_n_q  <= (state_d != LDAC);
`endif
      if (launch) begin
        shreg_q   <= launch_word << 1;
        sdi_q     <= launch_word[FRAME_BITS-1];
        sclk_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        if (sclk_rise) sclk_q <= 1'b1;
        // SDI only moves on the falling edge, giving the DAC a full half period of setup.
        if (sclk_fall) begin
          sclk_q <= 1'b0;
          if (last_bit) begin
            sdi_q <= 1'b0;
          end else begin
            sdi_q     <= shreg_q[FRAME_BITS-1];
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
      end
      if (launch_pend) begin
        pend_vld_q <= we;
        if (we) pend_word_q <= new_word;
      end else if (we && (state_q != IDLE) && !launch) begin
        pend_word_q <= new_word;
        pend_vld_q  <= 1'b1;
        if (pend_vld_q && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign bus.DAC_CS_N   = cs_n_q;
  assign bus.DAC_SCLK   = sclk_q;
  assign bus.DAC_SDI    = sdi_q;
  assign bus.BUSY       = (state_q != IDLE) | pend_vld_q;
  assign bus.DROP_COUNT = drop_q;
`ifdef DAC_SPI_SERIALIZER_LDAC_EN
  assign bus.DAC_LDAC_N = ldac_n_q;
`endif
endmodule
